// File: rtl/img_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : img_fetch
// Purpose  : Raster-driven image fetcher. Converts the HDMI timing position
//            (cx, cy) into row-major image-memory reads and re-aligns the
//            returned pixels with a delayed copy of the screen position.
// Revision : 1.0 - initial release
// ============================================================================
module img_fetch #(
  parameter int                IMG_WIDTH   = 356,
  parameter int                IMG_HEIGHT  = 356,
  parameter int                X_OFFSET    = 0,
  parameter int                Y_OFFSET    = 0,
  parameter int                MEM_LATENCY = 2,
  parameter int                PIX_W       = 8,
  parameter int                ADDR_W      = 17,
  parameter logic [PIX_W-1:0]  BG_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        cx,
  input  logic [9:0]        cy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pix,
  output logic              pix_valid,
  output logic [9:0]        pix_cx,
  output logic [9:0]        pix_cy,
  output logic              frame_start
);

  // Counter is one bit wider than the address so the saturation value
  // W*H is representable even when it equals 2^ADDR_W.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
  // Delay from stage 0 to the output register: one slot for the address
  // register plus MEM_LATENCY slots while the memory answers.
  localparam int                DLY     = MEM_LATENCY + 1;
  localparam logic [10:0]       X_LO    = 11'(X_OFFSET);
  localparam logic [10:0]       Y_LO    = 11'(Y_OFFSET);

  // Window test by offset subtraction: a position left of/above the window
  // wraps to a value above 1024, so one unsigned compare covers both edges.
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;

  assign dx   = {1'b0, cx} - X_LO;
  assign dy   = {1'b0, cy} - Y_LO;
  assign in_x = dx < 11'(IMG_WIDTH);
  assign in_y = dy < 11'(IMG_HEIGHT);

  logic       s0_vld;
  logic       s0_in_win;
  logic [9:0] s0_cx;
  logic [9:0] s0_cy;

  // Stage 0: capture the raster position and its window membership.
  // s0_vld keeps the reset value (0,0) from posing as a real frame origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld    <= 1'b0;
      s0_in_win <= 1'b0;
      s0_cx     <= '0;
      s0_cy     <= '0;
    end else begin
      s0_vld    <= 1'b1;
      s0_in_win <= in_x && in_y;
      s0_cx     <= cx;
      s0_cy     <= cy;
    end
  end

  logic             s0_origin;
  logic [CNT_W-1:0] addr_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic             synced;
  logic             issue;

  // An origin restarts the count in the same cycle, so an in-window origin
  // reads address 0 directly; a saturated count issues nothing.
  assign s0_origin = s0_vld && (s0_cx == 10'd0) && (s0_cy == 10'd0);
  assign cnt_base  = s0_origin ? '0 : addr_cnt;
  assign issue     = s0_in_win && (synced || s0_origin) && (cnt_base < CNT_MAX);

  // Address generation: counter-based row-major addressing and frame sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt  <= '0;
      synced    <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr <= cnt_base[ADDR_W-1:0];
        addr_cnt <= cnt_base + CNT_W'(1);
      end else begin
        addr_cnt <= cnt_base;
      end
      if (s0_origin) begin
        synced <= 1'b1;
      end
    end
  end

  logic [DLY-1:0]       pipe_ok;
  logic [DLY-1:0]       pipe_fs;
  logic [DLY-1:0][9:0]  pipe_cx;
  logic [DLY-1:0][9:0]  pipe_cy;

  // Alignment pipeline: carries "a read was issued", the origin marker and
  // the position alongside the in-flight memory access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_ok <= '0;
      pipe_fs <= '0;
      pipe_cx <= '0;
      pipe_cy <= '0;
    end else begin
      pipe_ok[0] <= issue;
      pipe_fs[0] <= s0_origin;
      pipe_cx[0] <= s0_cx;
      pipe_cy[0] <= s0_cy;
      for (int i = 1; i < DLY; i++) begin
        pipe_ok[i] <= pipe_ok[i-1];
        pipe_fs[i] <= pipe_fs[i-1];
        pipe_cx[i] <= pipe_cx[i-1];
        pipe_cy[i] <= pipe_cy[i-1];
      end
    end
  end

  // Output stage: memory data only in slots that carry an issued read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix         <= BG_VALUE;
      pix_valid   <= 1'b0;
      pix_cx      <= '0;
      pix_cy      <= '0;
      frame_start <= 1'b0;
    end else begin
      pix         <= pipe_ok[DLY-1] ? mem_data : BG_VALUE;
      pix_valid   <= pipe_ok[DLY-1];
      pix_cx      <= pipe_cx[DLY-1];
      pix_cy      <= pipe_cy[DLY-1];
      frame_start <= pipe_fs[DLY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_img_fetch
// Purpose  : Self-checking bench for img_fetch. Three instances (default
//            geometry, small offset window with latency 4, small window with
//            latency 1) share one raster stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_fetch;

  localparam int NDUT = 3;

  function automatic int cfg_w(input int i);
    case (i) 0: return 356; 1: return 4; default: return 8; endcase
  endfunction
  function automatic int cfg_h(input int i);
    case (i) 0: return 356; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int cfg_x(input int i);
    case (i) 0: return 0; 1: return 100; default: return 2; endcase
  endfunction
  function automatic int cfg_y(input int i);
    case (i) 0: return 0; 1: return 50; default: return 1; endcase
  endfunction
  function automatic int cfg_lat(input int i);
    case (i) 0: return 2; 1: return 4; default: return 1; endcase
  endfunction
  function automatic int cfg_aw(input int i);
    case (i) 0: return 17; 1: return 4; default: return 5; endcase
  endfunction
  function automatic logic [7:0] cfg_bg(input int i);
    case (i) 0: return 8'h00; 1: return 8'h80; default: return 8'h11; endcase
  endfunction

  // Memory content as a function of address.
  function automatic logic [7:0] mem_word(input logic [16:0] a);
    return (8'(a[7:0] * 8'd7) + 8'd3) ^ a[15:8];
  endfunction

  typedef struct packed {
    logic        ok;
    logic        fs;
    logic [16:0] addr;
    logic [9:0]  cx;
    logic [9:0]  cy;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cx;
  logic [9:0] cy;
  bit         chk_en;
  int         checks;
  int         errors;

  logic        mon_rd   [NDUT];
  logic [16:0] mon_addr [NDUT];
  logic        mon_pv   [NDUT];
  logic [7:0]  mon_pix  [NDUT];
  logic [9:0]  mon_pcx  [NDUT];
  logic [9:0]  mon_pcy  [NDUT];
  logic        mon_fs   [NDUT];
  int          n_rd     [NDUT];
  int          n_pv     [NDUT];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int         W    = cfg_w(g);
    localparam int         H    = cfg_h(g);
    localparam int         X    = cfg_x(g);
    localparam int         Y    = cfg_y(g);
    localparam int         LAT  = cfg_lat(g);
    localparam int         AW   = cfg_aw(g);
    localparam logic [7:0] BG   = cfg_bg(g);
    localparam int         L    = LAT + 2;
    localparam int         NPIX = W * H;

    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_data;
    logic [7:0]    pix;
    logic          pix_valid;
    logic [9:0]    pix_cx;
    logic [9:0]    pix_cy;
    logic          frame_start;
    logic [7:0]    rd_q [4];

    img_fetch #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_OFFSET(X), .Y_OFFSET(Y),
      .MEM_LATENCY(LAT), .PIX_W(8), .ADDR_W(AW), .BG_VALUE(BG)
    ) u_dut (
      .clk(clk), .rst(rst), .cx(cx), .cy(cy),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
      .pix(pix), .pix_valid(pix_valid), .pix_cx(pix_cx), .pix_cy(pix_cy),
      .frame_start(frame_start)
    );

    // Memory with LAT cycles of read latency; unrequested slots carry junk.
    always @(posedge clk) begin
      for (int k = 3; k > 0; k--) rd_q[k] <= rd_q[k-1];
      rd_q[0] <= mem_rd_en ? mem_word(17'(mem_addr)) : 8'hEE;
    end
    assign mem_data = rd_q[LAT-1];

    assign mon_rd[g]   = mem_rd_en;
    assign mon_addr[g] = 17'(mem_addr);
    assign mon_pv[g]   = pix_valid;
    assign mon_pix[g]  = pix;
    assign mon_pcx[g]  = pix_cx;
    assign mon_pcy[g]  = pix_cy;
    assign mon_fs[g]   = frame_start;

    // Reference model: e[d] is the prediction for the sample taken d edges ago.
    rec_t e [8];
    int   m_cnt;
    bit   m_sync;
    logic [16:0] m_last;

    always @(posedge clk or posedge rst) begin : p_model
      rec_t r;
      int   base;
      if (rst) begin
        for (int k = 0; k < 8; k++) e[k] = '0;
        m_cnt  = 0;
        m_sync = 1'b0;
        m_last = '0;
      end else begin
        r      = '0;
        r.cx   = cx;
        r.cy   = cy;
        r.fs   = (cx == 10'd0) && (cy == 10'd0);
        base   = r.fs ? 0 : m_cnt;
        r.ok   = (int'(cx) >= X) && (int'(cx) < X + W) &&
                 (int'(cy) >= Y) && (int'(cy) < Y + H) &&
                 (m_sync || r.fs) && (base < NPIX);
        r.addr = r.ok ? 17'(base) : m_last;
        m_last = r.addr;
        m_cnt  = r.ok ? base + 1 : base;
        if (r.fs) m_sync = 1'b1;
        for (int k = 7; k > 0; k--) e[k] = e[k-1];
        e[0] = r;
      end
    end

    always @(negedge clk) begin : p_check
      rec_t s;
      rec_t o;
      if (chk_en) begin
        s = e[1];
        o = e[L];
        chk($sformatf("model_dut%0d", g),
            {mem_rd_en, 17'(mem_addr), pix_valid, pix, pix_cx, pix_cy, frame_start},
            {s.ok, s.addr, o.ok, (o.ok ? mem_word(o.addr) : BG), o.cx, o.cy, o.fs});
      end
    end
  end

  // One raster sample: tally outputs seen at this negedge, then drive.
  task automatic step(input int x, input int y);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      n_rd[i] += int'(mon_rd[i]);
      n_pv[i] += int'(mon_pv[i]);
    end
    cx = 10'(x);
    cy = 10'(y);
  endtask

  task automatic scan(input int x0, input int y0, input int h, input int v);
    int x;
    int y;
    x = x0;
    y = y0;
    while (y < v) begin
      step(x, y);
      x++;
      if (x == h) begin
        x = 0;
        y++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1023, 1023);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NDUT; i++) begin
      n_rd[i] = 0;
      n_pv[i] = 0;
    end
  endtask

  typedef struct {
    int cx;
    int cy;
    bit a_rd;
    int a_addr;
    bit b_rd;
    int b_addr;
  } vec_t;

  vec_t tab [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    bit fs;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    cx = 10'd10;
    cy = 10'd10;
    clr_counts();

    //          cx   cy  a_rd a_addr b_rd b_addr
    tab[0]  = '{0,   0,   1,   0,    0,   0};
    tab[1]  = '{99,  49,  1,   1,    0,   0};
    tab[2]  = '{100, 49,  1,   2,    0,   0};
    tab[3]  = '{100, 50,  1,   3,    1,   0};
    tab[4]  = '{101, 50,  1,   4,    1,   1};
    tab[5]  = '{102, 50,  1,   5,    1,   2};
    tab[6]  = '{103, 50,  1,   6,    1,   3};
    tab[7]  = '{104, 50,  1,   7,    0,   0};
    tab[8]  = '{100, 51,  1,   8,    1,   4};
    tab[9]  = '{103, 53,  1,   9,    1,   5};
    tab[10] = '{104, 53,  1,   10,   0,   0};
    tab[11] = '{100, 54,  1,   11,   0,   0};
    tab[12] = '{0,   0,   1,   0,    0,   0};
    tab[13] = '{100, 50,  1,   1,    1,   0};
    tab[14] = '{355, 355, 1,   2,    0,   0};
    tab[15] = '{356, 355, 0,   0,    0,   0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("reset_state_dut%0d", i),
          {mon_rd[i], mon_addr[i], mon_pv[i], mon_pix[i], mon_pcx[i], mon_pcy[i], mon_fs[i]},
          {1'b0, 17'd0, 1'b0, cfg_bg(i), 10'd0, 10'd0, 1'b0});

    // Release at (10,10): nothing may be fetched before an origin.
    rst = 1'b0;
    scan(10, 10, 110, 56);
    idle(8);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("presync_quiet_dut%0d", i), {32'(n_rd[i]), 32'(n_pv[i])}, 64'd0);

    // Hand-computed vectors: strobe 2 steps later, output L+1 steps later.
    for (int i = 0; i < 24; i++) begin
      if (i < 16) step(tab[i].cx, tab[i].cy);
      else step(1023, 1023);
      if (i >= 2 && i - 2 < 16) begin
        j = i - 2;
        chk("tab_a_strobe", {mon_rd[0], (tab[j].a_rd ? mon_addr[0] : 17'd0)},
            {tab[j].a_rd, (tab[j].a_rd ? 17'(tab[j].a_addr) : 17'd0)});
        chk("tab_b_strobe", {mon_rd[1], (tab[j].b_rd ? mon_addr[1] : 17'd0)},
            {tab[j].b_rd, (tab[j].b_rd ? 17'(tab[j].b_addr) : 17'd0)});
      end
      if (i >= 5 && i - 5 < 16) begin
        j = i - 5;
        fs = (tab[j].cx == 0) && (tab[j].cy == 0);
        chk("tab_a_out", {mon_pv[0], mon_pix[0], mon_pcx[0], mon_pcy[0], mon_fs[0]},
            {tab[j].a_rd, (tab[j].a_rd ? mem_word(17'(tab[j].a_addr)) : 8'h00),
             10'(tab[j].cx), 10'(tab[j].cy), fs});
      end
      if (i >= 7 && i - 7 < 16) begin
        j = i - 7;
        fs = (tab[j].cx == 0) && (tab[j].cy == 0);
        chk("tab_b_out", {mon_pv[1], mon_pix[1], mon_pcx[1], mon_pcy[1], mon_fs[1]},
            {tab[j].b_rd, (tab[j].b_rd ? mem_word(17'(tab[j].b_addr)) : 8'h80),
             10'(tab[j].cx), 10'(tab[j].cy), fs});
      end
    end

    // Full frame: line 1 column 0 of the default image reads address 356.
    clr_counts();
    scan(0, 0, 360, 1);
    step(0, 1);
    step(1, 1);
    step(2, 1);
    chk("line1_col0_addr", {mon_rd[0], mon_addr[0]}, {1'b1, 17'd356});
    scan(3, 1, 360, 2);
    scan(0, 2, 110, 56);
    idle(8);
    chk("frame_strobes_b", {32'(n_rd[1]), 32'(n_pv[1])}, {32'd16, 32'd16});
    chk("frame_strobes_c", {32'(n_rd[2]), 32'(n_pv[2])}, {32'd24, 32'd24});

    // Second pass without an origin: small images stay saturated.
    clr_counts();
    scan(1, 0, 110, 56);
    idle(8);
    chk("saturated_b", {32'(n_rd[1]), 32'(n_pv[1])}, 64'd0);
    chk("saturated_c", {32'(n_rd[2]), 32'(n_pv[2])}, 64'd0);

    // Early origin mid-frame, then a complete frame.
    scan(0, 0, 110, 20);
    clr_counts();
    step(0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(k, 0);
      chk("early_fs_a", {63'd0, mon_fs[0]}, {63'd0, (k == 5)});
      chk("early_fs_b", {63'd0, mon_fs[1]}, {63'd0, (k == 7)});
    end
    scan(9, 0, 110, 56);
    idle(8);
    chk("resync_frame_b", {32'(n_rd[1]), 32'(n_pv[1])}, {32'd16, 32'd16});
    chk("resync_frame_c", {32'(n_rd[2]), 32'(n_pv[2])}, {32'd24, 32'd24});

    // Reset while reads of the small window are in flight.
    scan(0, 0, 110, 50);
    step(100, 50);
    step(101, 50);
    step(102, 50);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    clr_counts();
    scan(103, 50, 110, 56);
    idle(8);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("post_reset_quiet_dut%0d", i), {32'(n_rd[i]), 32'(n_pv[i])}, 64'd0);

    // Recovery after the next origin.
    clr_counts();
    scan(0, 0, 110, 56);
    idle(8);
    chk("recover_b", {32'(n_rd[1]), 32'(n_pv[1])}, {32'd16, 32'd16});
    chk("recover_c", {32'(n_rd[2]), 32'(n_pv[2])}, {32'd24, 32'd24});

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
